spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one SPI master (2..8).
REQ-002 Parameter DW, default 16: data width, equal to the SPI master data bus width.
REQ-003 Parameter TIMEOUT_CYC, default 255: watchdog limit in clk cycles (used only under REQ-027).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  NREQ  per-requester transfer request, level.
REQ-007 req_cpol, req_cpha  in  NREQ each  per-requester SPI mode.
REQ-008 req_len  in  4*NREQ  per-requester xfer_len, slice i = bits [4i+3:4i].
REQ-009 req_wdata  in  DW*NREQ  per-requester transmit word, slice i.
REQ-010 gnt  out  NREQ  one-hot grant, held for the whole transaction.
REQ-011 ack  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 rdata  out  DW  received word, valid in the ack cycle and held until the next ack.
REQ-013 err  out  1  timeout flag, pulses with ack.
REQ-014 spi_en, spi_we, spi_oe, spi_cpol, spi_cpha  out  1 each  master controls.
REQ-015 spi_len  out  4 and spi_wdata  out  DW: master length and transmit word; top-level tristates connect spi_wdata and spi_rdata to the master data bus.
REQ-016 spi_rdata  in  DW, spi_busy  in  1, spi_done  in  1: master status and data.
REQ-017 spi_rst  out  1  active-high master reset.
REQ-018 cs_sel  out  NREQ  one-hot slave-select steering; ss is demuxed by cs_sel.

Function
REQ-019 The FSM SHALL use the states IDLE, LOAD, RUN, DRAIN and ACK.
- IDLE: if any req is set, register a round-robin winner in gnt and cs_sel, then go to LOAD.
- LOAD (1 cycle): spi_we=1 and spi_en=1; spi_wdata, spi_cpol, spi_cpha and spi_len come from the granted slice.
- RUN: spi_en=1 until spi_done=1, then go to DRAIN.
- DRAIN: spi_oe=1. spi_en=1 while spi_busy=1. Once spi_busy=0, spi_en SHALL deassert combinationally in the same cycle, so the master never sees en at its idle state, and spi_rdata is latched into rdata.
- ACK (1 cycle): ack[i]=1, then go to IDLE.
REQ-020 spi_cpol, spi_cpha, spi_len and spi_wdata SHALL stay stable from LOAD through DRAIN.
REQ-021 Round-robin: search starts at the index after the last granted one and wraps modulo NREQ; after reset, index 0 has top priority.
REQ-022 A winner is chosen only in IDLE; a new req arriving mid-transaction waits.
REQ-023 If req drops while granted, the transaction still completes and ack still pulses.
REQ-024 Minimum gap between two transactions: 1 IDLE cycle after ACK.
REQ-025 Requesters SHALL hold their config slices stable while gnt is high; the arbiter does not re-sample them after LOAD.

Reset
REQ-026 While rst_n=0, the block SHALL hold:
- state=IDLE;
- gnt, ack, cs_sel, err, spi_en, spi_we, spi_oe, spi_cpol, spi_cpha = 0;
- spi_len, spi_wdata, rdata = 0;
- RR pointer = index 0;
- spi_rst=1, releasing one cycle after rst_n rises.
A mid-transaction reset aborts the transfer with no ack.

Configuration
REQ-027 Macro SPI_ARB_TIMEOUT_EN:
- When defined: a cycle counter runs in RUN/DRAIN. On reaching TIMEOUT_CYC, spi_en drops, spi_rst pulses 2 cycles, rdata = all-ones, and ack and err pulse together; the FSM then returns to IDLE.
- When undefined: no counter exists, err is tied 0, and spi_rst is driven only by reset.

Structure
REQ-028 Package spi_arb_pkg SHALL hold the FSM state encodings, the LEN_W=4 constant and the default DW/NREQ/TIMEOUT_CYC values.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and last-grant pointer; output one-hot winner).

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Single req[0], len=7, cpol=0, cpha=0, wdata=16'hA5A5, with a loopback slave -> exactly one ack[0] pulse, rdata=16'hA5A5, and spi_en low in the ack cycle.
- req=4'b1111 held -> grants in order 0,1,2,3,0; each gnt is one-hot and there is at least 1 idle cycle between acks.
- req[2] dropped during RUN -> the transfer completes and ack[2] pulses once.
- rst_n low during RUN -> all outputs go to 0 asynchronously, spi_rst=1, and no ack occurs.
- cpha=1 and cpol=1 on req[1] -> spi_cpha and spi_cpol are high from LOAD to DRAIN, and rdata matches the slave word.
- SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=20, spi_done stuck at 0 -> err and ack pulse at cycle 20 of RUN, spi_rst pulses 2 cycles, and rdata=16'hFFFF.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encodings, field widths
// and default parameter values.
package spi_arb_pkg;

  localparam int LEN_W           = 4;    // width of one xfer_len field
  localparam int PTR_W           = 3;    // round-robin pointer width (NREQ <= 8)
  localparam int DEF_NREQ        = 4;
  localparam int DEF_DW          = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ACK   = 3'd4
  } state_e;

  // Per-transaction SPI mode captured from the granted requester.
  typedef struct packed {
    logic             cpol;
    logic             cpha;
    logic [LEN_W-1:0] len;
  } spi_mode_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. ptr names the index holding top priority
// (one past the last grant); the search wraps modulo NREQ. Output is one-hot,
// or zero when nothing is requesting.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner
);

  logic [NREQ-1:0] upper;
  logic [NREQ-1:0] src;

  // Prefer requesters at or above ptr; fall back to the wrapped range, then
  // isolate the lowest set bit of whichever set is searched.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    upper = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper[i] = req[i] && (PTR_W'(i) >= ptr);
    end
    src    = (|upper) ? upper : req;
    winner = src & (~src + NREQ'(1));
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NREQ requesters.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort transfers that stay in
// RUN/DRAIN for TIMEOUT_CYC cycles (ack+err, rdata all-ones, 2-cycle spi_rst).
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_cpol,
  input  logic [NREQ-1:0]       req_cpha,
  input  logic [LEN_W*NREQ-1:0] req_len,
  input  logic [DW*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [DW-1:0]         rdata,
  output logic                  err,
  output logic                  spi_en,
  output logic                  spi_we,
  output logic                  spi_oe,
  output logic                  spi_cpol,
  output logic                  spi_cpha,
  output logic [LEN_W-1:0]      spi_len,
  output logic [DW-1:0]         spi_wdata,
  input  logic [DW-1:0]         spi_rdata,
  input  logic                  spi_busy,
  input  logic                  spi_done,
  output logic                  spi_rst,
  output logic [NREQ-1:0]       cs_sel
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  spi_mode_t        mode_q, mode_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             rst_hold_q;

  logic [NREQ-1:0]  pick;
  logic [PTR_W-1:0] ptr_next;
  spi_mode_t        sel_mode;
  logic [DW-1:0]    sel_wdata;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick)
  );

  // Priority pointer that would follow the current pick: one past it, wrapping.
  always_comb begin
    ptr_next = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) ptr_next = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  // Select the granted requester's config slice.
  always_comb begin
    sel_mode  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel_mode.cpol = req_cpol[i];
        sel_mode.cpha = req_cpha[i];
        sel_mode.len  = req_len[LEN_W*i +: LEN_W];
        sel_wdata     = req_wdata[DW*i +: DW];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic [1:0]       rst_cnt_q, rst_cnt_d;
  logic             tmo_hit;

  // Watchdog: count RUN/DRAIN cycles, flag the cycle the count reaches the limit.
  always_comb begin
    cnt_d   = '0;
    tmo_hit = 1'b0;
    if (state_q == ST_RUN || state_q == ST_DRAIN) begin
      cnt_d   = cnt_q + CNT_W'(1);
      tmo_hit = (cnt_d == CNT_W'(TIMEOUT_CYC));
    end
    tmo_d = tmo_q;
    if (tmo_hit) tmo_d = 1'b1;
    else if (state_q == ST_ACK) tmo_d = 1'b0;
    rst_cnt_d = rst_cnt_q;
    if (tmo_hit) rst_cnt_d = 2'd2;
    else if (rst_cnt_q != 2'd0) rst_cnt_d = rst_cnt_q - 2'd1;
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      rst_cnt_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign err     = (state_q == ST_ACK) && tmo_q;
  assign spi_rst = rst_hold_q | (rst_cnt_q != 2'd0);
`else
  // The watchdog limit has no effect without the timeout feature.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);

  assign err     = 1'b0;
  assign spi_rst = rst_hold_q;
`endif

  // Next-state and master-control decode.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    spi_en  = 1'b0;
    spi_we  = 1'b0;
    spi_oe  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          ptr_d   = ptr_next;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        spi_en  = 1'b1;
        spi_we  = 1'b1;
        mode_d  = sel_mode;
        wdata_d = sel_wdata;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        spi_en = 1'b1;
        if (spi_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        spi_oe = 1'b1;
        // en follows busy combinationally so it is already low on the
        // cycle the master reports idle.
        if (spi_busy) begin
          spi_en = 1'b1;
        end else begin
          rdata_d = spi_rdata;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SPI_ARB_TIMEOUT_EN
    if (tmo_hit) begin
      spi_en  = 1'b0;
      spi_oe  = 1'b0;
      rdata_d = '1;
      state_d = ST_ACK;
    end
`endif
  end

  // Arbiter state registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      mode_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      mode_q     <= mode_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rst_hold_q <= 1'b0;
    end
  end

  // In LOAD the master sees the live slice; afterwards the captured copy.
  assign spi_cpol  = (state_q == ST_LOAD) ? sel_mode.cpol : mode_q.cpol;
  assign spi_cpha  = (state_q == ST_LOAD) ? sel_mode.cpha : mode_q.cpha;
  assign spi_len   = (state_q == ST_LOAD) ? sel_mode.len  : mode_q.len;
  assign spi_wdata = (state_q == ST_LOAD) ? sel_wdata     : wdata_q;

  assign gnt    = gnt_q;
  assign cs_sel = gnt_q;
  assign ack    = (state_q == ST_ACK) ? gnt_q : '0;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed testbench for spi_arbiter with a behavioural SPI master/slave.
// The timeout scenario is compiled only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TB_TMO = 20;
`else
  localparam int TB_TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, req_cpol, req_cpha;
  logic [4*NREQ-1:0] req_len;
  logic [DW*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, ack, cs_sel;
  logic [DW-1:0]     rdata, spi_wdata, spi_rdata;
  logic              err, spi_en, spi_we, spi_oe, spi_cpol, spi_cpha, spi_rst;
  logic [3:0]        spi_len;
  logic              spi_busy, spi_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT_CYC(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cpol(req_cpol), .req_cpha(req_cpha),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .err(err), .spi_en(spi_en), .spi_we(spi_we), .spi_oe(spi_oe), .spi_cpol(spi_cpol),
    .spi_cpha(spi_cpha), .spi_len(spi_len), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rst(spi_rst), .cs_sel(cs_sel)
  );

  logic [53:0] all_outs;
  assign all_outs = {gnt, ack, cs_sel, err, spi_en, spi_we, spi_oe, spi_cpol, spi_cpha,
                     spi_len, spi_wdata, rdata};

  // ---------------- behavioural SPI master + slave ----------------
  // After the LOAD write: busy for len+2 cycles, done pulses two cycles
  // before busy falls so DRAIN sees one busy cycle first.
  logic [DW-1:0] m_word;
  int            m_cnt;
  logic          m_act;
  logic          loopback = 1'b1;
  logic [DW-1:0] slave_word = '0;
  logic          done_stuck = 1'b0;

  assign spi_rdata = loopback ? m_word : slave_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || spi_rst) begin
      m_act <= 1'b0; m_cnt <= 0; m_word <= '0; spi_busy <= 1'b0; spi_done <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      if (spi_en && spi_we) begin
        m_act <= 1'b1; m_cnt <= int'(spi_len) + 2; spi_busy <= 1'b1; m_word <= spi_wdata;
      end else if (m_act) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 3 && !done_stuck) spi_done <= 1'b1;
        if (m_cnt == 1) begin spi_busy <= 1'b0; m_act <= 1'b0; end
      end
    end
  end

  // ---------------- observation of one transaction ----------------
  logic [NREQ-1:0] obs_ack;
  logic [DW-1:0]   obs_rdata, obs_load_wdata;
  logic [3:0]      obs_load_len;
  logic            obs_err, obs_en_at_ack, obs_rst_at_ack, obs_cpol, obs_cpha;
  logic            obs_timeout, obs_mode_ok, obs_onehot_ok;
  int              obs_post_load;

  task automatic set_slice(input int i, input logic [3:0] len, input logic cpol,
                           input logic cpha, input logic [DW-1:0] wd);
    req_len[4*i +: 4]    = len;
    req_cpol[i]          = cpol;
    req_cpha[i]          = cpha;
    req_wdata[DW*i +: DW] = wd;
  endtask

  task automatic wait_ack(input bit drop_in_run, input int budget);
    bit load_seen = 1'b0;
    obs_ack = '0; obs_rdata = '0; obs_err = 1'b0; obs_en_at_ack = 1'b0; obs_rst_at_ack = 1'b0;
    obs_timeout = 1'b1; obs_mode_ok = 1'b1; obs_onehot_ok = 1'b1; obs_post_load = 0;
    obs_load_len = '0; obs_load_wdata = '0; obs_cpol = 1'b0; obs_cpha = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gnt != '0 && (!$onehot(gnt) || cs_sel !== gnt)) obs_onehot_ok = 1'b0;
      if (ack != '0) begin
        obs_ack = ack; obs_rdata = rdata; obs_err = err;
        obs_en_at_ack = spi_en; obs_rst_at_ack = spi_rst; obs_timeout = 1'b0;
        return;
      end
      if (spi_we) begin
        load_seen = 1'b1;
        obs_load_len = spi_len; obs_load_wdata = spi_wdata; obs_cpol = spi_cpol; obs_cpha = spi_cpha;
      end else if (load_seen) begin
        obs_post_load++;
        if (spi_cpol !== obs_cpol || spi_cpha !== obs_cpha ||
            spi_len !== obs_load_len || spi_wdata !== obs_load_wdata) obs_mode_ok = 1'b0;
        if (drop_in_run && spi_en && !spi_oe) req = '0;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
    checks++;
    if (spi_rst !== 1'b1) begin errors++; $display("FAIL reset_spi_rst: got %b want 1", spi_rst); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (spi_rst !== 1'b1) begin errors++; $display("FAIL spi_rst_hold: got %b want 1", spi_rst); end
    @(negedge clk);
    checks++;
    if (spi_rst !== 1'b0) begin errors++; $display("FAIL spi_rst_release: got %b want 0", spi_rst); end
  endtask

  task automatic test_single();
    set_slice(0, 4'd7, 1'b0, 1'b0, 16'hA5A5);
    loopback = 1'b1;
    req = 4'b0001;
    wait_ack(1'b0, 200);
    req = '0;
    checks++;
    if (obs_timeout) begin errors++; $display("FAIL single_ack_seen: got none want ack within 200 cycles"); end
    checks++;
    if (obs_ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", obs_ack); end
    checks++;
    if (obs_rdata !== 16'hA5A5) begin errors++; $display("FAIL single_rdata: got %h want a5a5", obs_rdata); end
    checks++;
    if (obs_en_at_ack !== 1'b0) begin errors++; $display("FAIL single_en_at_ack: got %b want 0", obs_en_at_ack); end
    checks++;
    if (obs_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", obs_err); end
    checks++;
    if (obs_load_len !== 4'd7 || obs_load_wdata !== 16'hA5A5) begin
      errors++; $display("FAIL single_load: got len=%0d wdata=%h want len=7 wdata=a5a5", obs_load_len, obs_load_wdata);
    end
    checks++;
    if (!obs_mode_ok || !obs_onehot_ok) begin
      errors++; $display("FAIL single_stable: got mode_ok=%b onehot_ok=%b want 1 1", obs_mode_ok, obs_onehot_ok);
    end
    @(negedge clk);
    checks++;
    if (ack !== '0 || rdata !== 16'hA5A5) begin
      errors++; $display("FAIL single_one_pulse: got ack=%b rdata=%h want ack=0000 rdata=a5a5", ack, rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] wd [NREQ];
    logic [NREQ-1:0] exp_ack;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      wd[i] = {4'(i + 1), 12'h3C5};
      set_slice(i, 4'(2 + i), 1'b0, 1'b0, wd[i]);
    end
    loopback = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ack = 4'b0001 << (k % NREQ);
      wait_ack(1'b0, 200);
      if (k == 4) req = '0;
      checks++;
      if (obs_ack !== exp_ack || obs_timeout) begin
        errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, obs_ack, exp_ack);
      end
      checks++;
      if (obs_rdata !== wd[k % NREQ] || !obs_onehot_ok) begin
        errors++; $display("FAIL rr_data[%0d]: got rdata=%h onehot=%b want %h 1", k, obs_rdata, obs_onehot_ok, wd[k % NREQ]);
      end
      @(negedge clk);
      checks++;
      if (gnt !== '0 || ack !== '0) begin
        errors++; $display("FAIL rr_gap[%0d]: got gnt=%b ack=%b want 0000 0000", k, gnt, ack);
      end
    end
  endtask

  task automatic test_drop_in_run();
    int extra = 0;
    set_slice(2, 4'd5, 1'b0, 1'b0, 16'hBEEF);
    loopback = 1'b1;
    req = 4'b0100;
    wait_ack(1'b1, 200);
    req = '0;
    checks++;
    if (obs_ack !== 4'b0100 || obs_timeout) begin errors++; $display("FAIL drop_ack: got %b want 0100", obs_ack); end
    checks++;
    if (obs_rdata !== 16'hBEEF) begin errors++; $display("FAIL drop_rdata: got %h want beef", obs_rdata); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack != '0) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL drop_single_pulse: got %0d extra acks want 0", extra); end
  endtask

  task automatic test_mid_reset();
    bit in_run = 1'b0;
    int acks = 0;
    set_slice(1, 4'd9, 1'b0, 1'b0, 16'h0F0F);
    req = 4'b0010;
    for (int c = 0; c < 50 && !in_run; c++) begin
      @(negedge clk);
      if (gnt != '0 && spi_en && !spi_we && !spi_oe) in_run = 1'b1;
    end
    checks++;
    if (!in_run) begin errors++; $display("FAIL midrst_reach_run: got no RUN want RUN within 50 cycles"); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", all_outs); end
    checks++;
    if (spi_rst !== 1'b1) begin errors++; $display("FAIL midrst_spi_rst: got %b want 1", spi_rst); end
    repeat (3) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks want 0", acks); end
  endtask

  task automatic test_mode();
    set_slice(1, 4'd4, 1'b1, 1'b1, 16'h1234);
    loopback = 1'b0;
    slave_word = 16'h5A3C;
    req = 4'b0010;
    wait_ack(1'b0, 200);
    req = '0;
    checks++;
    if (obs_ack !== 4'b0010 || obs_timeout) begin errors++; $display("FAIL mode_ack: got %b want 0010", obs_ack); end
    checks++;
    if (obs_cpol !== 1'b1 || obs_cpha !== 1'b1 || obs_load_len !== 4'd4) begin
      errors++; $display("FAIL mode_load: got cpol=%b cpha=%b len=%0d want 1 1 4", obs_cpol, obs_cpha, obs_load_len);
    end
    checks++;
    if (!obs_mode_ok) begin errors++; $display("FAIL mode_stable: got %b want 1", obs_mode_ok); end
    checks++;
    if (obs_rdata !== 16'h5A3C) begin errors++; $display("FAIL mode_rdata: got %h want 5a3c", obs_rdata); end
    loopback = 1'b1;
    @(negedge clk);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  // en drops on the cycle the count reaches TB_TMO (RUN cycle 20); ack/err follow.
  task automatic test_timeout();
    done_stuck = 1'b1;
    set_slice(0, 4'd3, 1'b0, 1'b0, 16'h7777);
    req = 4'b0001;
    wait_ack(1'b0, 200);
    req = '0;
    checks++;
    if (obs_ack !== 4'b0001 || obs_err !== 1'b1 || obs_timeout) begin
      errors++; $display("FAIL tmo_ack_err: got ack=%b err=%b want 0001 1", obs_ack, obs_err);
    end
    checks++;
    if (obs_post_load != TB_TMO) begin errors++; $display("FAIL tmo_cycles: got %0d want %0d", obs_post_load, TB_TMO); end
    checks++;
    if (obs_rdata !== 16'hFFFF) begin errors++; $display("FAIL tmo_rdata: got %h want ffff", obs_rdata); end
    checks++;
    if (obs_rst_at_ack !== 1'b1 || obs_en_at_ack !== 1'b0) begin
      errors++; $display("FAIL tmo_ack_cycle: got spi_rst=%b en=%b want 1 0", obs_rst_at_ack, obs_en_at_ack);
    end
    @(negedge clk);
    checks++;
    if (spi_rst !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL tmo_rst_2nd: got spi_rst=%b err=%b want 1 0", spi_rst, err);
    end
    @(negedge clk);
    checks++;
    if (spi_rst !== 1'b0) begin errors++; $display("FAIL tmo_rst_end: got %b want 0", spi_rst); end
    done_stuck = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req = '0; req_cpol = '0; req_cpha = '0; req_len = '0; req_wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop_in_run();
    test_mid_reset();
    test_mode();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finished by 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
